// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared constants, FSM encoding and element extraction for the GEMM core
package gemm_pkg;

   localparam int DEF_INP_WIDTH   = 8;
   localparam int DEF_WGT_WIDTH   = 8;
   localparam int DEF_ACC_WIDTH   = 32;
   localparam int DEF_BLOCK_IN    = 16;
   localparam int DEF_BLOCK_OUT   = 16;
   localparam int DEF_OUT_PER_CYC = 4;

   // Extraction works on a padded view so one function serves every width.
   localparam int MAX_VEC_W  = 4096;
   localparam int MAX_ELEM_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } gemm_state_t;

   function automatic logic [MAX_ELEM_W-1:0] elem_at(input logic [MAX_VEC_W-1:0] vec,
                                                     input int idx, input int w);
      logic [MAX_ELEM_W-1:0] mask;
      mask = (w >= MAX_ELEM_W) ? '1 : ((MAX_ELEM_W'(1) << w) - MAX_ELEM_W'(1));
      return MAX_ELEM_W'(vec >> (idx * w)) & mask;
   endfunction

   function automatic logic [MAX_ELEM_W-1:0] inp_elem(input logic [MAX_VEC_W-1:0] vec,
                                                      input int k, input int w);
      return elem_at(vec, k, w);
   endfunction

   function automatic logic [MAX_ELEM_W-1:0] wgt_elem(input logic [MAX_VEC_W-1:0] vec,
                                                      input int j, input int k,
                                                      input int w, input int block_in);
      return elem_at(vec, j * block_in + k, w);
   endfunction

   function automatic logic [MAX_ELEM_W-1:0] acc_elem(input logic [MAX_VEC_W-1:0] vec,
                                                      input int j, input int w);
      return elem_at(vec, j, w);
   endfunction

endpackage

// File: rtl/gemm_seq_core_if.sv
// rtl/gemm_seq_core_if.sv - operand/result handshake bundle of the GEMM core
interface gemm_seq_core_if
   import gemm_pkg::*;
#(
   parameter int INP_WIDTH   = DEF_INP_WIDTH,
   parameter int WGT_WIDTH   = DEF_WGT_WIDTH,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int BLOCK_IN    = DEF_BLOCK_IN,
   parameter int BLOCK_OUT   = DEF_BLOCK_OUT,
   parameter int OUT_PER_CYC = DEF_OUT_PER_CYC
);
   localparam int IT_WIDTH = INP_WIDTH * BLOCK_IN;
   localparam int WT_WIDTH = WGT_WIDTH * BLOCK_IN * BLOCK_OUT;
   localparam int AT_WIDTH = ACC_WIDTH * BLOCK_OUT;

   logic                in_valid;
   logic                in_ready;
   logic                signed_mode;
   logic                acc_rst;
   logic [IT_WIDTH-1:0] i_tensor;
   logic [WT_WIDTH-1:0] w_tensor;
   logic [AT_WIDTH-1:0] a_tensor;
   logic                out_valid;
   logic                out_ready;
   logic [AT_WIDTH-1:0] o_tensor;
   logic                busy;

   modport master (
      output in_valid, signed_mode, acc_rst, i_tensor, w_tensor, a_tensor, out_ready,
      input  in_ready, out_valid, o_tensor, busy
   );

   modport slave (
      input  in_valid, signed_mode, acc_rst, i_tensor, w_tensor, a_tensor, out_ready,
      output in_ready, out_valid, o_tensor, busy
   );

endinterface

// File: rtl/gemm_dot.sv
// rtl/gemm_dot.sv - one output lane: BLOCK_IN-long dot product plus accumulator add
module gemm_dot
   import gemm_pkg::*;
#(
   parameter int INP_WIDTH = DEF_INP_WIDTH,
   parameter int WGT_WIDTH = DEF_WGT_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int BLOCK_IN  = DEF_BLOCK_IN
)(
   input  logic                          signed_mode,
   input  logic [INP_WIDTH*BLOCK_IN-1:0] inp,
   input  logic [WGT_WIDTH*BLOCK_IN-1:0] wgt_row,
   input  logic [ACC_WIDTH-1:0]          acc,
   output logic [ACC_WIDTH-1:0]          res
);
   localparam int PW = INP_WIDTH + WGT_WIDTH;

   logic [INP_WIDTH-1:0] ie;
   logic [WGT_WIDTH-1:0] we;
   logic [PW-1:0]        ix;
   logic [PW-1:0]        wx;
   logic [PW-1:0]        prod;
   logic [ACC_WIDTH-1:0] pe;
   logic [ACC_WIDTH-1:0] sum;

   // Extended operands make the low PW bits of the product exact for both modes;
   // the running sum wraps modulo 2^ACC_WIDTH, matching the final truncation.
   always_comb begin
      ie   = '0;
      we   = '0;
      ix   = '0;
      wx   = '0;
      prod = '0;
      pe   = '0;
      sum  = acc;
      for (int k = 0; k < BLOCK_IN; k++) begin
         ie = INP_WIDTH'(inp_elem(MAX_VEC_W'(inp), k, INP_WIDTH));
         we = WGT_WIDTH'(wgt_elem(MAX_VEC_W'(wgt_row), 0, k, WGT_WIDTH, BLOCK_IN));
         if (signed_mode) begin
            ix = PW'($signed(ie));
            wx = PW'($signed(we));
         end else begin
            ix = PW'(ie);
            wx = PW'(we);
         end
         prod = ix * wx;
         if (signed_mode)
            pe = ACC_WIDTH'($signed(prod));
         else
            pe = ACC_WIDTH'(prod);
         sum = sum + pe;
      end
      res = sum;
   end

endmodule

// File: rtl/gemm_seq_core.sv
// rtl/gemm_seq_core.sv - time-multiplexed GEMM micro-op engine, OUT_PER_CYC lanes per beat
module gemm_seq_core
   import gemm_pkg::*;
#(
   parameter int INP_WIDTH   = DEF_INP_WIDTH,
   parameter int WGT_WIDTH   = DEF_WGT_WIDTH,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int BLOCK_IN    = DEF_BLOCK_IN,
   parameter int BLOCK_OUT   = DEF_BLOCK_OUT,
   parameter int OUT_PER_CYC = DEF_OUT_PER_CYC
)(
   input  logic           clk,
   input  logic           rst,
   gemm_seq_core_if.slave bus
);
   localparam int IT_WIDTH = INP_WIDTH * BLOCK_IN;
   localparam int ROW_W    = WGT_WIDTH * BLOCK_IN;
   localparam int WT_WIDTH = ROW_W * BLOCK_OUT;
   localparam int AT_WIDTH = ACC_WIDTH * BLOCK_OUT;
   localparam int NBEATS   = BLOCK_OUT / OUT_PER_CYC;
   localparam int BEAT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   gemm_state_t         state;
   logic [BEAT_W-1:0]   beat;
   logic [IT_WIDTH-1:0] i_reg;
   logic [WT_WIDTH-1:0] w_reg;
   logic [AT_WIDTH-1:0] a_reg;
   logic                sm_reg;
   logic [AT_WIDTH-1:0] o_reg;
   logic                in_ready_r;
   logic                out_valid_r;
   logic                busy_r;

   logic [ROW_W-1:0]     lane_row [OUT_PER_CYC];
   logic [ACC_WIDTH-1:0] lane_acc [OUT_PER_CYC];
   logic [ACC_WIDTH-1:0] lane_res [OUT_PER_CYC];

   // Beat-indexed selection of the weight rows and accumulators feeding the lanes.
   always_comb begin
      for (int l = 0; l < OUT_PER_CYC; l++) begin
         lane_row[l] = w_reg[(int'(beat) * OUT_PER_CYC + l) * ROW_W +: ROW_W];
         lane_acc[l] = ACC_WIDTH'(acc_elem(MAX_VEC_W'(a_reg),
                                           int'(beat) * OUT_PER_CYC + l, ACC_WIDTH));
      end
   end

   for (genvar l = 0; l < OUT_PER_CYC; l++) begin : g_lane
      gemm_dot #(
         .INP_WIDTH (INP_WIDTH),
         .WGT_WIDTH (WGT_WIDTH),
         .ACC_WIDTH (ACC_WIDTH),
         .BLOCK_IN  (BLOCK_IN)
      ) u_dot (
         .signed_mode (sm_reg),
         .inp         (i_reg),
         .wgt_row     (lane_row[l]),
         .acc         (lane_acc[l]),
         .res         (lane_res[l])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         beat        <= '0;
         i_reg       <= '0;
         w_reg       <= '0;
         a_reg       <= '0;
         sm_reg      <= 1'b0;
         o_reg       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  i_reg      <= bus.i_tensor;
                  w_reg      <= bus.w_tensor;
                  a_reg      <= bus.acc_rst ? '0 : bus.a_tensor;
                  sm_reg     <= bus.signed_mode;
                  beat       <= '0;
                  state      <= ST_COMPUTE;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            ST_COMPUTE: begin
               for (int l = 0; l < OUT_PER_CYC; l++)
                  o_reg[(int'(beat) * OUT_PER_CYC + l) * ACC_WIDTH +: ACC_WIDTH] <= lane_res[l];
               // beat parks at zero so the lane mux never indexes past the last row
               if (beat == LAST_BEAT) begin
                  beat        <= '0;
                  state       <= ST_DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.o_tensor  = o_reg;

endmodule

// File: tb/tb_gemm_seq_core.sv
// tb/tb_gemm_seq_core.sv - scoreboard bench for gemm_seq_core
module tb_gemm_seq_core;
   import gemm_pkg::*;

   localparam int IW = 8, WW = 8, AW = 32, BI = 16, BO = 16, OPC = 4;
   localparam int NB  = BO / OPC;
   localparam int ITW = IW * BI, WTW = ITW * BO, ATW = AW * BO;

   typedef struct {
      string          name;
      logic [ATW-1:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic srst;
   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   gemm_seq_core_if #(.INP_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(AW),
                      .BLOCK_IN(BI), .BLOCK_OUT(BO), .OUT_PER_CYC(OPC)) bus ();

   gemm_seq_core #(.INP_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(AW),
                   .BLOCK_IN(BI), .BLOCK_OUT(BO), .OUT_PER_CYC(OPC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic chkv(input string name, input logic [ATW-1:0] act, input logic [ATW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [ITW-1:0] fill_i(input logic [IW-1:0] v);
      logic [ITW-1:0] r;
      for (int k = 0; k < BI; k++) r[k*IW +: IW] = v;
      return r;
   endfunction

   function automatic logic [WTW-1:0] fill_w(input logic [WW-1:0] v);
      logic [WTW-1:0] r;
      for (int k = 0; k < BI * BO; k++) r[k*WW +: WW] = v;
      return r;
   endfunction

   function automatic logic [ATW-1:0] fill_a(input logic [AW-1:0] v);
      logic [ATW-1:0] r;
      for (int j = 0; j < BO; j++) r[j*AW +: AW] = v;
      return r;
   endfunction

   function automatic logic [WTW-1:0] rows_w();
      logic [WTW-1:0] r;
      for (int j = 0; j < BO; j++)
         for (int k = 0; k < BI; k++) r[j*ITW + k*WW +: WW] = WW'(j);
      return r;
   endfunction

   function automatic logic [ATW-1:0] rows_exp();
      logic [ATW-1:0] r;
      for (int j = 0; j < BO; j++) r[j*AW +: AW] = AW'(16 * j);
      return r;
   endfunction

   task automatic drive(input logic [ITW-1:0] i, input logic [WTW-1:0] w, input logic [ATW-1:0] a,
                        input logic sm, input logic ar);
      bus.i_tensor    = i;
      bus.w_tensor    = w;
      bus.a_tensor    = a;
      bus.signed_mode = sm;
      bus.acc_rst     = ar;
      bus.in_valid    = 1'b1;
   endtask

   // Drives one bundle, waits for acceptance, then scrambles the inputs.
   task automatic issue(input logic [ITW-1:0] i, input logic [WTW-1:0] w, input logic [ATW-1:0] a,
                        input logic sm, input logic ar, input logic [ATW-1:0] expv,
                        input bit push, input string name);
      int n;
      drive(i, w, a, sm, ar);
      if (push) exp_q.push_back('{name, expv});
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk({name, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #2;
      bus.in_valid    = 1'b0;
      bus.i_tensor    = '1;
      bus.w_tensor    = '1;
      bus.a_tensor    = '1;
      bus.signed_mode = ~sm;
      bus.acc_rst     = ~ar;
   endtask

   task automatic wait_lat(input string name);
      int n;
      bit ir_ok;
      n = 0;
      ir_ok = 1'b1;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.in_ready || !bus.busy) ir_ok = 1'b0;
         if (bus.out_valid) break;
      end
      chk({name, "_latency"}, 32'(n), 32'(NB));
      chk({name, "_in_ready_low"}, 32'(ir_ok), 32'd1);
      if (bus.out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got %h want none", bus.o_tensor);
            end else begin
               e = exp_q.pop_front();
               chkv(e.name, bus.o_tensor, e.v);
            end
         end
      end
   end

   // Smaller configurations checked against an integer reference model.
   for (genvar g = 0; g < 2; g++) begin : sw
      localparam int SOPC = (g == 0) ? 1 : 8;
      localparam int SBI = 8, SBO = 8, SNB = SBO / SOPC;
      localparam int SITW = IW * SBI, SWTW = SITW * SBO, SATW = AW * SBO;

      logic             done_f = 1'b0;
      logic [SATW-1:0]  sq[$];

      gemm_seq_core_if #(.INP_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(AW),
                         .BLOCK_IN(SBI), .BLOCK_OUT(SBO), .OUT_PER_CYC(SOPC)) sbus ();

      gemm_seq_core #(.INP_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(AW),
                      .BLOCK_IN(SBI), .BLOCK_OUT(SBO), .OUT_PER_CYC(SOPC)) sdut (
         .clk (clk),
         .rst (srst),
         .bus (sbus)
      );

      function automatic logic [SATW-1:0] sref(input logic [SITW-1:0] i, input logic [SWTW-1:0] w,
                                               input logic [SATW-1:0] a, input logic sm,
                                               input logic ar);
         logic [SATW-1:0] r;
         logic [31:0]     acc;
         logic [7:0]      ie, we;
         int              x, y;
         for (int j = 0; j < SBO; j++) begin
            acc = ar ? 32'd0 : a[j*AW +: AW];
            for (int k = 0; k < SBI; k++) begin
               ie = i[k*IW +: IW];
               we = w[j*SITW + k*WW +: WW];
               x = sm ? int'($signed(ie)) : int'(ie);
               y = sm ? int'($signed(we)) : int'(we);
               acc = acc + 32'(x * y);
            end
            r[j*AW +: AW] = acc;
         end
         return r;
      endfunction

      initial begin : drv
         logic [SITW-1:0] iv;
         logic [SWTW-1:0] wv;
         logic [SATW-1:0] av;
         logic            sm, ar;
         int              n;
         sbus.in_valid = 1'b0;
         sbus.out_ready = 1'b1;
         sbus.signed_mode = 1'b0;
         sbus.acc_rst = 1'b0;
         sbus.i_tensor = '0;
         sbus.w_tensor = '0;
         sbus.a_tensor = '0;
         #20;
         wait (srst === 1'b0);
         for (int t = 0; t < 4; t++) begin
            for (int b = 0; b < SITW; b += 32) iv[b +: 32] = $urandom();
            for (int b = 0; b < SWTW; b += 32) wv[b +: 32] = $urandom();
            for (int b = 0; b < SATW; b += 32) av[b +: 32] = $urandom();
            sm = t[0];
            ar = (t == 3);
            @(posedge clk);
            #2;
            sbus.i_tensor = iv;
            sbus.w_tensor = wv;
            sbus.a_tensor = av;
            sbus.signed_mode = sm;
            sbus.acc_rst = ar;
            sbus.in_valid = 1'b1;
            sq.push_back(sref(iv, wv, av, sm, ar));
            n = 0;
            @(negedge clk);
            while (!sbus.in_ready && n < 50) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk);
            #2;
            sbus.in_valid = 1'b0;
            sbus.i_tensor = '0;
            sbus.signed_mode = ~sm;
            n = 0;
            while (n < 40) begin
               @(posedge clk);
               #1;
               n++;
               if (sbus.out_valid) break;
            end
            chk($sformatf("sweep%0d_latency", g), 32'(n), 32'(SNB));
            @(posedge clk);
            #1;
         end
         chk($sformatf("sweep%0d_drained", g), 32'(sq.size()), 32'd0);
         done_f = 1'b1;
      end

      initial begin : smon
         logic [SATW-1:0] e;
         forever begin
            @(negedge clk);
            if (sbus.out_valid && sbus.out_ready) begin
               if (sq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sweep%0d_unexpected: got %h want none", g, sbus.o_tensor);
               end else begin
                  e = sq.pop_front();
                  chkv($sformatf("sweep%0d_result", g), ATW'(sbus.o_tensor), ATW'(e));
               end
            end
         end
      end
   end

   initial begin : main
      bit ok;
      int n;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b1;
      bus.signed_mode = 1'b0;
      bus.acc_rst     = 1'b0;
      bus.i_tensor    = '0;
      bus.w_tensor    = '0;
      bus.a_tensor    = '0;
      rst  = 1'b1;
      srst = 1'b1;
      #12;
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chkv("reset_o_tensor", bus.o_tensor, '0);
      @(posedge clk);
      #2;
      rst  = 1'b0;
      srst = 1'b0;
      @(posedge clk);
      #2;

      issue(fill_i(8'd1), fill_w(8'd1), fill_a(32'd0), 1'b0, 1'b0, fill_a(32'd16), 1, "unsigned_ones");
      wait_lat("unsigned_ones");
      issue(fill_i(8'hFF), fill_w(8'd2), fill_a(32'd100), 1'b1, 1'b0, fill_a(32'd68), 1, "signed_neg");
      wait_lat("signed_neg");
      issue(fill_i(8'hFF), fill_w(8'd2), fill_a(32'd100), 1'b0, 1'b0, fill_a(32'd8260), 1, "unsigned_ff");
      wait_lat("unsigned_ff");
      issue(fill_i(8'd1), fill_w(8'd1), fill_a(32'h7FFFFFFF), 1'b1, 1'b0, fill_a(32'h8000000F), 1, "wrap");
      wait_lat("wrap");
      issue(fill_i(8'd1), fill_w(8'd1), fill_a(32'h7FFFFFFF), 1'b1, 1'b1, fill_a(32'd16), 1, "acc_rst");
      wait_lat("acc_rst");
      issue(fill_i(8'd1), rows_w(), fill_a(32'd0), 1'b0, 1'b0, rows_exp(), 1, "row_order");
      wait_lat("row_order");

      // Result held under backpressure while stray in_valid pulses arrive.
      bus.out_ready = 1'b0;
      issue(fill_i(8'd2), fill_w(8'd3), fill_a(32'd1), 1'b0, 1'b0, fill_a(32'd97), 1, "backpressure");
      wait_lat("backpressure");
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!(bus.out_valid && !bus.in_ready && bus.busy && bus.o_tensor == fill_a(32'd97))) ok = 1'b0;
         @(posedge clk);
         #2;
         bus.in_valid = ~bus.in_valid;
      end
      chk("bp_hold_stable", 32'(ok), 32'd1);
      drive(fill_i(8'd1), fill_w(8'd1), fill_a(32'd3), 1'b0, 1'b0);
      exp_q.push_back('{"after_bp", fill_a(32'd19)});
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_next_accept_busy", 32'(bus.busy), 32'd1);
      #1;
      bus.in_valid = 1'b0;
      bus.a_tensor = '1;
      wait_lat("after_bp");

      // Reset in the middle of an op.
      issue(fill_i(8'd3), fill_w(8'd3), fill_a(32'd7), 1'b0, 1'b0, '0, 0, "killed");
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chkv("midrst_o_tensor", bus.o_tensor, '0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      issue(fill_i(8'd1), fill_w(8'd1), fill_a(32'd5), 1'b0, 1'b0, fill_a(32'd21), 1, "post_reset");
      wait_lat("post_reset");

      n = 0;
      while (!(sw[0].done_f && sw[1].done_f) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      chk("sweep_finished", 32'(sw[0].done_f && sw[1].done_f), 32'd1);
      @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
